// File: rtl/sr_cmd_if.sv
// Request handshake carrying "make Q equal v" commands into the SR command driver.
interface sr_cmd_if;
  logic req_valid;
  logic req_ready;
  logic req_val;
  logic req_force;

  modport master (output req_valid, output req_val, output req_force, input req_ready);
  modport slave  (input req_valid, input req_val, input req_force, output req_ready);
endinterface

// File: rtl/sr_cmd_driver.sv
// Drives legal S/R pulses into one SR flip-flop, reads Q back and retries a bounded
// number of times before reporting an error.
module sr_cmd_driver #(
  parameter int PULSE_W   = 2,
  parameter int SETTLE_W  = 1,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  sr_cmd_if.slave          cmd,
  input  logic             q_fb,
  output logic             S,
  output logic             R,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] rst_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DRIVE  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  localparam int PH_MAX = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int ATT_W  = $clog2(MAX_RETRY + 2);

  localparam logic [PH_W-1:0]  PULSE_LAST  = PH_W'(PULSE_W - 1);
  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_W - 1);
  localparam logic [ATT_W-1:0] ATT_LAST    = ATT_W'(MAX_RETRY + 1);

  logic [2:0]       state, state_d;
  logic             tgt, tgt_d;
  logic [PH_W-1:0]  phase, phase_d;
  logic [ATT_W-1:0] attempts, att_d;
  logic             err_d;
  logic             drive_entry;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d     = state;
    tgt_d       = tgt;
    phase_d     = phase;
    att_d       = attempts;
    err_d       = 1'b0;
    drive_entry = 1'b0;

    case (state)
      IDLE: begin
        if (cmd.req_valid) begin
          tgt_d = cmd.req_val;
          att_d = '0;
          // X/Z on q_fb must never look like a match, hence the case equality.
          if (!cmd.req_force && (q_fb === cmd.req_val)) state_d = RESP;
          else                                          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (phase == PULSE_LAST) begin
          state_d = SETTLE;
          phase_d = '0;
        end else begin
          phase_d = phase + PH_W'(1);
        end
      end
      SETTLE: begin
        if (phase == SETTLE_LAST) begin
          state_d = CHECK;
          phase_d = '0;
        end else begin
          phase_d = phase + PH_W'(1);
        end
      end
      CHECK: begin
        if (q_fb === tgt) begin
          state_d = RESP;
        end else if (attempts < ATT_LAST) begin
          state_d = DRIVE;
        end else begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // One count per pulse: only the transition into DRIVE counts, not its cycles.
    drive_entry = (state_d == DRIVE) && (state != DRIVE);
    if (drive_entry) begin
      att_d   = att_d + ATT_W'(1);
      phase_d = '0;
    end
  end

  // Outputs are registered from the next state so S/R line up with the state they belong to.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state         <= IDLE;
      tgt           <= 1'b0;
      phase         <= '0;
      attempts      <= '0;
      S             <= 1'b0;
      R             <= 1'b0;
      cmd.req_ready <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      set_cnt       <= '0;
      rst_cnt       <= '0;
    end else begin
      state         <= state_d;
      tgt           <= tgt_d;
      phase         <= phase_d;
      attempts      <= att_d;
      S             <= (state_d == DRIVE) &&  tgt_d;
      R             <= (state_d == DRIVE) && !tgt_d;
      cmd.req_ready <= (state_d == IDLE);
      busy          <= (state_d != IDLE);
      done          <= (state_d == RESP);
      err           <= (state_d == RESP) && err_d;
      if (drive_entry &&  tgt_d && (set_cnt != {CNT_W{1'b1}})) set_cnt <= set_cnt + CNT_W'(1);
      if (drive_entry && !tgt_d && (rst_cnt != {CNT_W{1'b1}})) rst_cnt <= rst_cnt + CNT_W'(1);
    end
  end

endmodule
